ahb_default_slave: RTL and testbench
====================================

Name: ahb_default_slave

Overview:
- Parametrised successor to the fixed-response AHB dummy slave.
- Sits on AHB-Lite decode holes and unpopulated peripheral slots as the default slave.
- Responds to every selected transfer with programmable wait states and either a two-cycle ERROR or an OKAY with a constant read value.
- Logs the address of the last faulting access and raises a sticky interrupt.

Parameters:
- ADDR_W, 32, haddr width.
- DATA_W, 32, hrdata/hwdata width (32 or 64).
- WAIT_CYCLES, 0, data-phase wait states before the response, 0..15.
- ERR_MODE, 1, 1 = two-cycle ERROR response; 0 = OKAY response.
- RDATA_VAL, 0, read data returned in OKAY mode, DATA_W bits.
- CNT_W, 8, width of the saturating error counter.
- INTR_EN, 1, 1 = intr driven from the pending flag; 0 = intr tied 0.

Ports:
- hclk  in  1  clock.
- hrst  in  1  reset; synchronous, active-high.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  address.
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  write strobe.
- hsize  in  3  transfer size.
- hprot  in  4  protection bits; unused, ignored.
- hwdata  in  DATA_W  write data; ignored.
- hready  in  1  bus ready from the interconnect (hready_in).
- hready_resp  out  1  slave ready.
- hresp  out  2  00 OKAY, 01 ERROR.
- hrdata  out  DATA_W  read data.
- intr_clr  in  1  one-cycle pulse that clears the pending interrupt.
- err_addr  out  ADDR_W  haddr of the most recent erroring transfer.
- err_write  out  1  hwrite of that transfer.
- err_cnt  out  CNT_W  saturating error count.
- intr  out  1  level interrupt.

Behaviour:
- Accept condition: hsel & hready & htrans[1], sampled on the hclk edge. On accept, latch haddr, hwrite and hsize. The data phase starts the next cycle.
- IDLE/BUSY, or not selected: no data phase. Output hready_resp=1, hresp=OKAY (zero-wait OKAY).
- FSM states: IDLE, WAIT, ERR1, ERR2, DONE.
  - IDLE -> accept -> WAIT if WAIT_CYCLES>0; else ERR1 (ERR_MODE=1) or DONE (ERR_MODE=0).
  - WAIT: hready_resp=0, hresp=OKAY. Lasts exactly WAIT_CYCLES cycles using a 4-bit down-counter, then goes to ERR1 or DONE.
  - ERR1: hready_resp=0, hresp=ERROR. Always goes to ERR2.
  - ERR2: hready_resp=1, hresp=ERROR.
  - DONE: hready_resp=1, hresp=OKAY. hrdata=RDATA_VAL if the latched hwrite=0, else 0.
  - From ERR2 or DONE: if accept in the same cycle, restart (back-to-back); else go to IDLE.
- hrdata is 0 in every state except DONE-read.
- Total data-phase length: ERROR = WAIT_CYCLES+2 cycles; OKAY = WAIT_CYCLES+1 cycles.
- Master cancellation: a master that drives IDLE during ERR2 after receiving ERROR gets no further data phase.
- Error log, updated on entry to ERR1:
  - err_addr and err_write take the latched values; latest error overwrites.
  - err_cnt increments and saturates at 2^CNT_W-1.
  - pending is set.
- Error log in ERR_MODE=0: never updated; intr stays 0.
- intr = pending & INTR_EN.
- intr_clr clears pending. If intr_clr coincides with an ERR1 entry, the set wins and pending stays 1.
- intr_clr does not clear err_addr or err_cnt.
- Reset values: state=IDLE, hready_resp=1, hresp=00, hrdata=0, err_addr=0, err_write=0, err_cnt=0, pending=0, intr=0.
- Reset asserted mid-transfer forces all of the above on the next edge; the in-flight transfer is abandoned.
- hsize and hprot do not affect the response.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants.
  - The default-slave state enum.
  - The accept-condition helper function.
- One natural sub-module: ahb_default_err_log, containing the capture registers, saturating counter and pending/intr logic. It is driven by an err_evt pulse and the latched attributes.

Test Plan:
1. WAIT_CYCLES=0, ERR_MODE=1; NONSEQ read to 0x4000_1000 -> next cycle hready_resp=0/hresp=01, then hready_resp=1/hresp=01; err_addr=0x4000_1000, err_write=0, err_cnt=1, intr=1.
2. WAIT_CYCLES=3, ERR_MODE=0, RDATA_VAL=0xDEAD_BEEF; read -> 3 cycles hready_resp=0/OKAY, 4th cycle hready_resp=1, hrdata=0xDEADBEEF; intr stays 0, err_cnt=0.
3. Back-to-back: NONSEQ write 0x10 then SEQ write 0x14 presented in ERR2 -> second data phase starts immediately after ERR2; err_addr=0x14, err_write=1, err_cnt=2.
4. IDLE and BUSY with hsel=1, and NONSEQ with hready=0 -> hready_resp stays 1, hresp=OKAY, no log update.
5. intr_clr on the same edge as an ERR1 entry -> intr stays 1; intr_clr alone later -> intr=0 next cycle, err_cnt unchanged. CNT_W=2 with 5 errors -> err_cnt=3.
6. hrst=1 during WAIT (WAIT_CYCLES=5) -> next edge hready_resp=1, hresp=00, err_cnt=0, intr=0; a new NONSEQ after reset completes a normal full response.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants, default-slave state encoding and the transfer
// accept helper used by the default slave and its error log.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    DS_IDLE = 3'd0,
    DS_WAIT = 3'd1,
    DS_ERR1 = 3'd2,
    DS_ERR2 = 3'd3,
    DS_DONE = 3'd4
  } ds_state_e;

  // A transfer is taken only for NONSEQ/SEQ while selected and the bus is ready.
  function automatic logic ahb_accept(input logic hsel, input logic hready,
                                      input logic [1:0] htrans);
    return hsel & hready & htrans[1];
  endfunction

endpackage

// File: rtl/ahb_default_slave_if.sv
// AHB-Lite slave-side signal bundle for the default slave.
interface ahb_default_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hready_resp;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    output hready_resp, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    input  hready_resp, hresp, hrdata
  );

endinterface

// File: rtl/ahb_default_err_log.sv
// Fault log for the default slave: captures the last erroring address/direction,
// keeps a saturating error count and a sticky pending interrupt.
module ahb_default_err_log #(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 8,
  parameter int INTR_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              err_evt_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              write_i,
  input  logic              intr_clr_i,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              err_write_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              intr_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic             INTR_ON = (INTR_EN != 0);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              intr_q, intr_d;

  // Next log state; a new error outranks a simultaneous clear.
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (err_evt_i) begin
      addr_d  = addr_i;
      write_d = write_i;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      pend_d  = 1'b1;
    end else begin
      pend_d  = intr_clr_i ? 1'b0 : pend_q;
    end
    intr_d = pend_d & INTR_ON;
  end

  // Log registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      intr_q  <= intr_d;
    end
  end

  assign err_addr_o  = addr_q;
  assign err_write_o = write_q;
  assign err_cnt_o   = cnt_q;
  assign intr_o      = intr_q;

endmodule

// File: rtl/ahb_default_slave.sv
// AHB-Lite default slave: programmable wait states followed by a two-cycle
// ERROR or a constant-data OKAY, with a fault log and sticky interrupt.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                WAIT_CYCLES = 0,
  parameter int                ERR_MODE    = 1,
  parameter logic [DATA_W-1:0] RDATA_VAL   = '0,
  parameter int                CNT_W       = 8,
  parameter int                INTR_EN     = 1
) (
  input  logic                hclk,
  input  logic                hrst,
  ahb_default_slave_if.slave  bus,
  input  logic                intr_clr,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                err_write,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                intr
);

  localparam ds_state_e  POST_WAIT = (ERR_MODE != 0) ? DS_ERR1 : DS_DONE;
  localparam ds_state_e  FIRST     = (WAIT_CYCLES > 0) ? DS_WAIT : POST_WAIT;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  ds_state_e         state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic              ready_q, ready_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept_s;
  logic              err_evt_s;
  logic              unused_ok;

  assign accept_s  = ahb_accept(bus.hsel, bus.hready, bus.htrans);
  assign err_evt_s = (state_d == DS_ERR1);
  assign unused_ok = ^{size_q, bus.hprot, bus.hwdata};

  // Next state plus the response the bus will see in that state.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      DS_IDLE, DS_ERR2, DS_DONE: begin
        if (accept_s) begin
          state_d = FIRST;
          wcnt_d  = WAIT_INIT;
          addr_d  = bus.haddr;
          write_d = bus.hwrite;
          size_d  = bus.hsize;
        end else begin
          state_d = DS_IDLE;
        end
      end
      DS_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = POST_WAIT;
        end else begin
          wcnt_d  = wcnt_q - 4'd1;
        end
      end
      DS_ERR1: state_d = DS_ERR2;
      default: state_d = DS_IDLE;
    endcase

    ready_d = 1'b1;
    resp_d  = HRESP_OKAY;
    rdata_d = '0;
    case (state_d)
      DS_WAIT: ready_d = 1'b0;
      DS_ERR1: begin
        ready_d = 1'b0;
        resp_d  = HRESP_ERROR;
      end
      DS_ERR2: resp_d  = HRESP_ERROR;
      DS_DONE: rdata_d = write_d ? '0 : RDATA_VAL;
      default: begin
      end
    endcase
  end

  // State, latched transfer attributes and registered bus response.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q <= DS_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.hready_resp = ready_q;
  assign bus.hresp       = resp_q;
  assign bus.hrdata      = rdata_q;

  ahb_default_err_log #(
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .INTR_EN (INTR_EN)
  ) u_err_log (
    .clk_i       (hclk),
    .rst_i       (hrst),
    .err_evt_i   (err_evt_s),
    .addr_i      (addr_d),
    .write_i     (write_d),
    .intr_clr_i  (intr_clr),
    .err_addr_o  (err_addr),
    .err_write_o (err_write),
    .err_cnt_o   (err_cnt),
    .intr_o      (intr)
  );

endmodule

// File: tb/tb_ahb_default_slave.sv
// Bench for ahb_default_slave: four configurations share one stimulus stream and
// are checked every cycle against a per-transfer response-script model.
module tb_ahb_default_slave;
  import ahb_pkg::*;

  localparam int NCFG = 4;

  function automatic int cfg_wait(input int i);
    case (i)
      1:       return 3;
      3:       return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_err(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int cfg_cntw(input int i);
    return (i == 2) ? 2 : 8;
  endfunction

  function automatic int cfg_intr(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic logic [31:0] cfg_rdata(input int i);
    case (i)
      0:       return 32'h1234_5678;
      1:       return 32'hDEAD_BEEF;
      default: return 32'hA5A5_0F0F;
    endcase
  endfunction

  logic        hclk = 1'b0;
  logic        hrst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        intr_clr;

  logic        rdy_a   [NCFG];
  logic [1:0]  resp_a  [NCFG];
  logic [31:0] rdata_a [NCFG];
  logic [31:0] eaddr_a [NCFG];
  logic        ewr_a   [NCFG];
  logic [31:0] cnt_a   [NCFG];
  logic        intr_a  [NCFG];

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int CW = cfg_cntw(g);
    ahb_default_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic [CW-1:0] cnt_s;

    assign bus.hsel   = hsel;
    assign bus.haddr  = haddr;
    assign bus.htrans = htrans;
    assign bus.hwrite = hwrite;
    assign bus.hsize  = hsize;
    assign bus.hprot  = hprot;
    assign bus.hwdata = hwdata;
    assign bus.hready = hready;

    ahb_default_slave #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .WAIT_CYCLES (cfg_wait(g)),
      .ERR_MODE    (cfg_err(g)),
      .RDATA_VAL   (cfg_rdata(g)),
      .CNT_W       (CW),
      .INTR_EN     (cfg_intr(g))
    ) dut (
      .hclk      (hclk),
      .hrst      (hrst),
      .bus       (bus),
      .intr_clr  (intr_clr),
      .err_addr  (eaddr_a[g]),
      .err_write (ewr_a[g]),
      .err_cnt   (cnt_s),
      .intr      (intr_a[g])
    );

    assign rdy_a[g]   = bus.hready_resp;
    assign resp_a[g]  = bus.hresp;
    assign rdata_a[g] = bus.hrdata;
    assign cnt_a[g]   = 32'(cnt_s);
  end

  // Model: each accepted transfer becomes a script of per-cycle responses.
  // Entry bits: [0] hready_resp, [1] ERROR, [2] returns read data, [3] logs error.
  int          len      [NCFG];
  int          pos      [NCFG];
  logic [3:0]  scr      [NCFG][0:19];
  logic [31:0] lat_addr [NCFG];
  logic        lat_wr   [NCFG];
  logic [31:0] m_addr   [NCFG];
  logic        m_wr     [NCFG];
  int          m_cnt    [NCFG];
  logic        m_pend   [NCFG];

  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] cur_entry(input int i);
    return (pos[i] < len[i]) ? scr[i][pos[i]] : 4'b0001;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NCFG; i++) begin
      logic [3:0] e;
      e = cur_entry(i);
      if (hrst) begin
        len[i] = 0; pos[i] = 0;
        m_addr[i] = 32'h0; m_wr[i] = 1'b0; m_cnt[i] = 0; m_pend[i] = 1'b0;
      end else begin
        if (pos[i] < len[i]) pos[i]++;
        if (hsel && hready && htrans[1] && e[0]) begin
          len[i] = 0; pos[i] = 0;
          for (int k = 0; k < cfg_wait(i); k++) begin
            scr[i][len[i]] = 4'b0000; len[i]++;
          end
          if (cfg_err(i) != 0) begin
            scr[i][len[i]] = 4'b1010; scr[i][len[i] + 1] = 4'b0011; len[i] += 2;
          end else begin
            scr[i][len[i]] = {1'b0, ~hwrite, 2'b01}; len[i]++;
          end
          lat_addr[i] = haddr; lat_wr[i] = hwrite;
        end
        e = cur_entry(i);
        if (e[3]) begin
          m_addr[i] = lat_addr[i]; m_wr[i] = lat_wr[i]; m_pend[i] = 1'b1;
          if (m_cnt[i] < (1 << cfg_cntw(i)) - 1) m_cnt[i]++;
        end else if (intr_clr) begin
          m_pend[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input int i, input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h at %0t", i, name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCFG; i++) begin
      logic [3:0] e;
      e = cur_entry(i);
      chk(i, "hready_resp", 32'(rdy_a[i]), 32'(e[0]));
      chk(i, "hresp", 32'(resp_a[i]), {31'h0, e[1]});
      chk(i, "hrdata", rdata_a[i], e[2] ? cfg_rdata(i) : 32'h0);
      chk(i, "err_addr", eaddr_a[i], m_addr[i]);
      chk(i, "err_write", 32'(ewr_a[i]), 32'(m_wr[i]));
      chk(i, "err_cnt", cnt_a[i], 32'(m_cnt[i]));
      chk(i, "intr", 32'(intr_a[i]), 32'(m_pend[i] && (cfg_intr(i) != 0)));
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    hrst = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = 3'd2; hprot = 4'h3; hwdata = 32'h0; hready = 1'b1; intr_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCFG; i++) begin
      len[i] = 0; pos[i] = 0; lat_addr[i] = 32'h0; lat_wr[i] = 1'b0;
      m_addr[i] = 32'h0; m_wr[i] = 1'b0; m_cnt[i] = 0; m_pend[i] = 1'b0;
    end
    idle_in();
    hrst = 1'b1;
    repeat (2) cyc();
    chk(0, "rst_ready", 32'(rdy_a[0]), 32'h1);
    chk(3, "rst_cnt", cnt_a[3], 32'h0);
    hrst = 1'b0;
    cyc();

    // Single ERROR on cfg0 and a waited OKAY read on cfg1.
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h4000_1000;
    cyc();
    chk(0, "t1_err1_ready", 32'(rdy_a[0]), 32'h0);
    chk(0, "t1_err1_resp", 32'(resp_a[0]), 32'h1);
    chk(0, "t1_err_addr", eaddr_a[0], 32'h4000_1000);
    chk(0, "t1_err_write", 32'(ewr_a[0]), 32'h0);
    chk(0, "t1_err_cnt", cnt_a[0], 32'h1);
    chk(0, "t1_intr", 32'(intr_a[0]), 32'h1);
    chk(1, "t2_wait1_ready", 32'(rdy_a[1]), 32'h0);
    htrans = HTRANS_IDLE;
    cyc();
    chk(0, "t1_err2_ready", 32'(rdy_a[0]), 32'h1);
    chk(0, "t1_err2_resp", 32'(resp_a[0]), 32'h1);
    cyc();
    chk(1, "t2_wait3_ready", 32'(rdy_a[1]), 32'h0);
    cyc();
    chk(1, "t2_done_ready", 32'(rdy_a[1]), 32'h1);
    chk(1, "t2_done_resp", 32'(resp_a[1]), 32'h0);
    chk(1, "t2_done_rdata", rdata_a[1], 32'hDEAD_BEEF);
    chk(1, "t2_cnt", cnt_a[1], 32'h0);
    chk(1, "t2_intr", 32'(intr_a[1]), 32'h0);

    // Back-to-back writes, second presented in ERR2 together with intr_clr.
    htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h10;
    cyc();
    htrans = HTRANS_IDLE;
    cyc();
    htrans = HTRANS_SEQ; haddr = 32'h14; intr_clr = 1'b1;
    cyc();
    chk(0, "t3_b2b_ready", 32'(rdy_a[0]), 32'h0);
    chk(0, "t3_b2b_resp", 32'(resp_a[0]), 32'h1);
    chk(0, "t3_err_addr", eaddr_a[0], 32'h14);
    chk(0, "t3_err_write", 32'(ewr_a[0]), 32'h1);
    chk(0, "t3_err_cnt", cnt_a[0], 32'h3);
    chk(0, "t5_set_wins", 32'(intr_a[0]), 32'h1);
    htrans = HTRANS_IDLE; intr_clr = 1'b0;
    repeat (8) cyc();
    intr_clr = 1'b1;
    cyc();
    chk(0, "t5_intr_cleared", 32'(intr_a[0]), 32'h0);
    chk(0, "t5_cnt_kept", cnt_a[0], 32'h3);
    intr_clr = 1'b0;

    // Non-transfers while selected.
    htrans = HTRANS_BUSY;
    cyc();
    chk(0, "t4_busy_ready", 32'(rdy_a[0]), 32'h1);
    htrans = HTRANS_NONSEQ; hready = 1'b0;
    cyc();
    chk(0, "t4_noready_ready", 32'(rdy_a[0]), 32'h1);
    chk(0, "t4_noready_resp", 32'(resp_a[0]), 32'h0);
    chk(0, "t4_noready_cnt", cnt_a[0], 32'h3);
    idle_in();
    repeat (10) cyc();

    // Reset in the middle of cfg3's wait states.
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h2000_0000;
    cyc();
    htrans = HTRANS_IDLE;
    cyc();
    hrst = 1'b1;
    cyc();
    chk(3, "t6_rst_ready", 32'(rdy_a[3]), 32'h1);
    chk(3, "t6_rst_resp", 32'(resp_a[3]), 32'h0);
    chk(3, "t6_rst_cnt", cnt_a[3], 32'h0);
    chk(3, "t6_rst_intr", 32'(intr_a[3]), 32'h0);
    hrst = 1'b0;

    // Continuous NONSEQ: cfg2 takes five errors and saturates its 2-bit count.
    htrans = HTRANS_NONSEQ;
    repeat (10) cyc();
    chk(2, "t5_cnt_sat", cnt_a[2], 32'h3);
    chk(2, "t5_intr_disabled", 32'(intr_a[2]), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      hrst     = ($urandom_range(0, 199) == 0);
      hsel     = ($urandom_range(0, 3) != 0);
      htrans   = 2'($urandom_range(0, 3));
      hready   = ($urandom_range(0, 4) != 0);
      hwrite   = 1'($urandom_range(0, 1));
      haddr    = $urandom & 32'hFFFF_FFFC;
      hsize    = 3'($urandom_range(0, 3));
      hprot    = 4'($urandom_range(0, 15));
      hwdata   = $urandom;
      intr_clr = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
